hdmi_fmt_ctrl: RTL and testbench

Sequences the HDMI output path (timing generator, test-pattern generator, TMDS serializer) through power-up, hot-plug and video-format changes, all in the pixel-clock domain. It sits between the register bank and the video chain. It owns the `fmt_def` fed to the timing and pattern generators, their generate-enable, and the serializer reset. A format change is applied only at a frame boundary, with the output muted and the serializer re-reset, so the sink never sees a torn frame.

---
 rtl/hdmi_ctrl_pkg.sv | 20 ++
 rtl/hdmi_sync_deb.sv | 56 +++++
 rtl/hdmi_fmt_ctrl.sv | 151 +++++++++++++++
 tb/tb_hdmi_fmt_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_ctrl_pkg.sv
// Shared types and helpers for the HDMI output-path sequencer.
package hdmi_ctrl_pkg;

    localparam int unsigned FmtW = 3;

    typedef logic [FmtW-1:0] fmt_t;

    typedef enum logic [2:0] {
        StOff,
        StRst,
        StMute,
        StRun,
        StDrain
    } state_e;

    function automatic logic fmt_valid(input fmt_t code, input fmt_t max);
        return code <= max;
    endfunction

endpackage

// File: rtl/hdmi_sync_deb.sv
// Two-flop synchronizer with optional stability filter; DEB=0 bypasses the filter.
module hdmi_sync_deb #(
    parameter int unsigned DEB     = 0,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    if (DEB == 0) begin : g_nodeb
        assign q_o = sync_q[1];
    end else begin : g_deb
        localparam int unsigned CntW = (DEB > 1) ? $clog2(DEB) : 1;

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            deb_q, deb_d;

        // Count consecutive samples that disagree with the accepted level.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync_q[1] != deb_q) begin
                if (cnt_q == CntW'(DEB - 1)) begin
                    deb_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                deb_q <= RST_VAL;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign q_o = deb_q;
    end

endmodule

// File: rtl/hdmi_fmt_ctrl.sv
// Sequences timing generator, pattern generator and serializer reset through
// power-up, hot-plug and frame-aligned video-format changes.
module hdmi_fmt_ctrl
    import hdmi_ctrl_pkg::*;
#(
    parameter int unsigned DEF_FMT     = 0,
    parameter int unsigned FMT_MAX     = 4,
    parameter int unsigned RST_CYC     = 16,
    parameter int unsigned MUTE_FRAMES = 2,
    parameter int unsigned HPD_DEB     = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [FmtW-1:0] fmt_req,
    input  logic            pll_locked,
    input  logic            hpd,
    input  logic            vtg_vblank,
    output logic [FmtW-1:0] fmt_def,
    output logic            gen_ce,
    output logic            tx_rst_n,
    output logic            mute,
    output logic            busy,
    output logic            fmt_err,
    output logic            switch_done
);

    localparam fmt_t FmtMax = fmt_t'(FMT_MAX);
    localparam fmt_t FmtDef = fmt_t'(DEF_FMT);

    logic lock_s, hpd_ok;

    hdmi_sync_deb #(
        .DEB     (0),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    hdmi_sync_deb #(
        .DEB     (HPD_DEB),
        .RST_VAL (1'b0)
    ) u_hpd_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (hpd),
        .q_o   (hpd_ok)
    );

    // Format request: synchronize, then accept only a value seen twice in a row.
    fmt_t req_s1_q, req_s2_q, pend_q;
    logic fmt_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1_q  <= FmtDef;
            req_s2_q  <= FmtDef;
            pend_q    <= FmtDef;
            fmt_err_q <= 1'b0;
        end else begin
            req_s1_q <= fmt_req;
            req_s2_q <= req_s1_q;
            if (req_s1_q == req_s2_q) begin
                pend_q    <= req_s2_q;
                fmt_err_q <= !fmt_valid(req_s2_q, FmtMax);
            end
        end
    end

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       vblank_q;
    fmt_t       fmt_def_q;
    logic       gen_ce_q, tx_rst_n_q, mute_q, busy_q, done_q;

    logic vb_rise, link_up, pend_new;

    assign vb_rise  = vtg_vblank & ~vblank_q;
    assign link_up  = lock_s & hpd_ok;
    assign pend_new = fmt_valid(pend_q, FmtMax) && (pend_q != fmt_def_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StOff: begin
                if (link_up) state_d = StRst;
            end
            StRst: begin
                if (cnt_q == 8'(RST_CYC - 1)) state_d = StMute;
                else cnt_d = cnt_q + 8'd1;
            end
            StMute: begin
                if (pend_new) begin
                    state_d = StRst;
                end else if (vb_rise) begin
                    if (cnt_q == 8'(MUTE_FRAMES - 1)) state_d = StRun;
                    else cnt_d = cnt_q + 8'd1;
                end
            end
            StRun: begin
                if (pend_new) state_d = StDrain;
            end
            StDrain: begin
                if (vb_rise) state_d = StRst;
            end
            default: state_d = StOff;
        endcase
        // Losing the link wins over every frame-aligned transition.
        if (!link_up) state_d = StOff;
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they move with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            vblank_q   <= 1'b0;
            fmt_def_q  <= FmtDef;
            gen_ce_q   <= 1'b0;
            tx_rst_n_q <= 1'b0;
            mute_q     <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vblank_q <= vtg_vblank;
            if (state_d == StRst && state_q != StRst && fmt_valid(pend_q, FmtMax)) begin
                fmt_def_q <= pend_q;
            end
            gen_ce_q   <= state_d inside {StMute, StRun, StDrain};
            tx_rst_n_q <= state_d inside {StMute, StRun, StDrain};
            mute_q     <= state_d != StRun;
            busy_q     <= state_d != StRun;
            done_q     <= (state_d == StRun) && (state_q != StRun);
        end
    end

    assign fmt_def     = fmt_def_q;
    assign gen_ce      = gen_ce_q;
    assign tx_rst_n    = tx_rst_n_q;
    assign mute        = mute_q;
    assign busy        = busy_q;
    assign fmt_err     = fmt_err_q;
    assign switch_done = done_q;

endmodule

// File: tb/tb_hdmi_fmt_ctrl.sv
// Scoreboard bench for hdmi_fmt_ctrl: expected applied formats are queued at
// stimulus time and checked whenever the controller pulses switch_done.
module tb_hdmi_fmt_ctrl;

    localparam int FmtMax = 4;
    localparam int DefFmt = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fmt_req = 3'd0;
    logic       pll_locked = 1'b1;
    logic       hpd = 1'b1;
    logic       vtg_vblank = 1'b0;
    logic [2:0] fmt_def;
    logic       gen_ce, tx_rst_n, mute, busy, fmt_err, switch_done;

    int n_pass = 0;
    int n_chk  = 0;
    int exp_q[$];
    int model_fmt;

    hdmi_fmt_ctrl #(
        .DEF_FMT     (DefFmt),
        .FMT_MAX     (FmtMax),
        .RST_CYC     (16),
        .MUTE_FRAMES (2),
        .HPD_DEB     (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fmt_req     (fmt_req),
        .pll_locked  (pll_locked),
        .hpd         (hpd),
        .vtg_vblank  (vtg_vblank),
        .fmt_def     (fmt_def),
        .gen_ce      (gen_ce),
        .tx_rst_n    (tx_rst_n),
        .mute        (mute),
        .busy        (busy),
        .fmt_err     (fmt_err),
        .switch_done (switch_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leave RUN (if still there), then wait for the next RUN entry.
    task automatic wait_switch(input string name);
        int k;
        k = 0;
        while (!busy && k < 20) begin cyc(1); k++; end
        k = 0;
        while (busy && k < 600) begin cyc(1); k++; end
        check({name, "_reach_run"}, int'(busy), 0);
    endtask

    task automatic wait_vb_fall();
        int k;
        k = 0;
        while (!vtg_vblank && k < 100) begin cyc(1); k++; end
        while (vtg_vblank && k < 200) begin cyc(1); k++; end
    endtask

    // Free-running frame: 34 active cycles, 6 blanking cycles.
    initial begin
        forever begin
            repeat (34) @(negedge clk);
            vtg_vblank = 1'b1;
            repeat (6) @(negedge clk);
            vtg_vblank = 1'b0;
        end
    end

    // Monitor: every RUN entry must match the oldest outstanding expected format.
    always @(negedge clk) begin : monitor
        int e;
        if (rst_n && switch_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_switch_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_fmt_def", int'(fmt_def), e);
                check("done_mute", int'(mute), 0);
                check("done_tx_rst_n", int'(tx_rst_n), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, seen, code;
        model_fmt = DefFmt;
        #12;
        check("rst_fmt_def", int'(fmt_def), DefFmt);
        check("rst_gen_ce", int'(gen_ce), 0);
        check("rst_tx_rst_n", int'(tx_rst_n), 0);
        check("rst_mute", int'(mute), 1);
        check("rst_busy", int'(busy), 1);
        check("rst_fmt_err", int'(fmt_err), 0);
        check("rst_switch_done", int'(switch_done), 0);

        // Power-up: 2 sync + 16 debounce + 1 -> RST; 16 cycles of RST.
        exp_q.push_back(DefFmt);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(34);
        check("pwr_tx_rst_held", int'(tx_rst_n), 0);
        cyc(1);
        check("pwr_tx_rst_rise", int'(tx_rst_n), 1);
        check("pwr_mute_in_mute", int'(mute), 1);
        wait_switch("pwr");

        // Format switch 0 -> 3 mid-line.
        wait_vb_fall();
        cyc(5);
        fmt_req = 3'd3;
        exp_q.push_back(3);
        model_fmt = 3;
        cyc(3);
        check("sw_mute_early", int'(mute), 0);
        cyc(1);
        check("sw_mute", int'(mute), 1);
        check("sw_fmt_hold", int'(fmt_def), 0);
        check("sw_gen_ce_drain", int'(gen_ce), 1);
        k = 0;
        while (gen_ce && k < 100) begin cyc(1); k++; end
        check("sw_fmt_on_rst", int'(fmt_def), 3);
        n = 0;
        while (!gen_ce && n < 100) begin cyc(1); n++; end
        check("sw_gen_ce_low_cycles", n, 16);
        wait_switch("sw");

        // Invalid request is flagged and ignored.
        cyc(5);
        fmt_req = 3'd6;
        cyc(2);
        check("inv_err_early", int'(fmt_err), 0);
        cyc(1);
        check("inv_err", int'(fmt_err), 1);
        cyc(10);
        check("inv_stay_run", int'(busy), 0);
        check("inv_fmt_hold", int'(fmt_def), 3);
        fmt_req = 3'd2;
        exp_q.push_back(2);
        model_fmt = 2;
        cyc(3);
        check("inv_err_clear", int'(fmt_err), 0);
        wait_switch("inv_recover");

        // Back-to-back: new request while muted goes straight to RST.
        cyc(5);
        fmt_req = 3'd1;
        k = 0;
        while (tx_rst_n && k < 100) begin cyc(1); k++; end
        while (!tx_rst_n && k < 200) begin cyc(1); k++; end
        check("b2b_in_mute", int'(mute), 1);
        fmt_req = 3'd4;
        exp_q.push_back(4);
        model_fmt = 4;
        cyc(3);
        check("b2b_tx_rst_early", int'(tx_rst_n), 1);
        cyc(1);
        check("b2b_direct_rst", int'(tx_rst_n), 0);
        check("b2b_fmt_def", int'(fmt_def), 4);
        wait_switch("b2b");

        // Short hpd glitch is filtered.
        hpd = 1'b0;
        cyc(10);
        hpd = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (busy) seen = 1;
        end
        check("hpd_glitch_no_effect", seen, 0);

        // Unplug during DRAIN: 2 sync + 16 debounce + 1 cycles to OFF.
        wait_vb_fall();
        cyc(2);
        fmt_req = 3'd0;
        cyc(4);
        check("unplug_drain_mute", int'(mute), 1);
        check("unplug_drain_tx", int'(tx_rst_n), 1);
        hpd = 1'b0;
        k = 0;
        while (tx_rst_n && k < 40) begin cyc(1); k++; end
        check("unplug_latency", k, 19);
        check("unplug_mute", int'(mute), 1);
        check("unplug_gen_ce", int'(gen_ce), 0);
        cyc(10);
        check("unplug_stay_off", int'(tx_rst_n), 0);
        hpd = 1'b1;
        exp_q.push_back(0);
        model_fmt = 0;
        wait_switch("replug");

        // Lock loss: OFF three cycles later.
        cyc(5);
        pll_locked = 1'b0;
        cyc(2);
        check("lock_tx_early", int'(tx_rst_n), 1);
        cyc(1);
        check("lock_off_tx", int'(tx_rst_n), 0);
        check("lock_off_busy", int'(busy), 1);
        pll_locked = 1'b1;
        exp_q.push_back(model_fmt);
        wait_switch("relock");

        // Randomized requests against the model.
        for (int it = 0; it < 12; it++) begin
            cyc(int'($urandom_range(1, 30)));
            if ($urandom_range(0, 3) == 0) begin
                hpd = 1'b0;
                cyc(int'($urandom_range(1, 12)));
                hpd = 1'b1;
                cyc(20);
                check("rnd_glitch", int'(busy), 0);
            end
            code = int'($urandom_range(0, 7));
            fmt_req = 3'(code);
            if (code > FmtMax) begin
                cyc(3);
                check("rnd_err", int'(fmt_err), 1);
                cyc(10);
                check("rnd_err_run", int'(busy), 0);
                check("rnd_err_fmt", int'(fmt_def), model_fmt);
            end else if (code == model_fmt) begin
                cyc(3);
                check("rnd_same_err", int'(fmt_err), 0);
                cyc(20);
                check("rnd_same_run", int'(busy), 0);
                check("rnd_same_fmt", int'(fmt_def), model_fmt);
            end else begin
                exp_q.push_back(code);
                model_fmt = code;
                cyc(3);
                check("rnd_new_err", int'(fmt_err), 0);
                wait_switch("rnd");
            end
        end

        // Async reset in the middle of RST.
        code = (model_fmt == 3) ? 1 : 3;
        fmt_req = 3'(code);
        k = 0;
        while (gen_ce && k < 100) begin cyc(1); k++; end
        cyc(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fmt_def", int'(fmt_def), DefFmt);
        check("arst_gen_ce", int'(gen_ce), 0);
        check("arst_tx_rst_n", int'(tx_rst_n), 0);
        check("arst_mute", int'(mute), 1);
        check("arst_busy", int'(busy), 1);
        check("arst_fmt_err", int'(fmt_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(code);
        model_fmt = code;
        wait_switch("arst_restart");

        cyc(5);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
